// File: rtl/unit_clause_checker.sv
// Per-clause unit detector for the BCP engine: flags a clause that is unsatisfied with exactly one
// literal not yet false. Optional macro UNIT_CHECKER_CONFLICT_EN adds a registered all-false conflict flag.
module unit_clause_checker #(
   parameter int size = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            en_part_sat,
   input  logic            part_sat,
   input  logic [size-1:0] counter,
   input  logic [size-1:0] clause_size,
`ifdef UNIT_CHECKER_CONFLICT_EN
   output logic            conflict,
`endif
   output logic            unit_clause
);

   logic            sat_q;
   logic            sat_eff;
   logic            size_nonzero;
   logic [size-1:0] size_minus_one;
   logic            unit_d;

   // A fresh part_sat is evaluated together with the counts of the same edge.
   always_comb begin
      sat_eff        = en_part_sat ? part_sat : sat_q;
      size_nonzero   = (clause_size != '0);
      size_minus_one = clause_size - size'(1);
      // The explicit non-zero test stops clause_size=0 from matching counter=all-ones after wrap.
      unit_d         = !sat_eff && size_nonzero && (counter == size_minus_one);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sat_q       <= 1'b0;
         unit_clause <= 1'b0;
      end else begin
         sat_q       <= sat_eff;
         unit_clause <= unit_d;
      end
   end

`ifdef UNIT_CHECKER_CONFLICT_EN
   logic conflict_d;

   // Mutually exclusive with unit_d: counter cannot equal both clause_size and clause_size-1.
   always_comb begin
      conflict_d = !sat_eff && size_nonzero && (counter == clause_size);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         conflict <= 1'b0;
      end else begin
         conflict <= conflict_d;
      end
   end
`endif

endmodule

// File: tb/tb_unit_clause_checker.sv
// Self-checking bench for unit_clause_checker: directed scenarios plus randomized traffic compared
// against a count-based reference model (open literals = clause_size - counter).
module tb_unit_clause_checker;

   logic       clock;
   logic       reset_n;
   logic       en_part_sat;
   logic       part_sat;
   logic [7:0] counter;
   logic [7:0] clause_size;
   logic       unit_clause;
   logic       conflict;

   logic [1:0] exp_q[$];
   logic       model_sat;
   int         n_cmp;
   int         n_err;

   unit_clause_checker #(.size(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .en_part_sat (en_part_sat),
      .part_sat    (part_sat),
      .counter     (counter),
      .clause_size (clause_size),
`ifdef UNIT_CHECKER_CONFLICT_EN
      .conflict    (conflict),
`endif
      .unit_clause (unit_clause)
   );

`ifndef UNIT_CHECKER_CONFLICT_EN
   assign conflict = 1'b0;
`endif

   // clock / reset block
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // Driver plus model: applies one cycle of inputs and queues the expected {conflict, unit}.
   task automatic step(input logic rn, input logic en, input logic ps,
                       input logic [7:0] cnt, input logic [7:0] cs);
      int   open_lits;
      logic s_eff;
      logic eu;
      logic ec;
      reset_n     = rn;
      en_part_sat = en;
      part_sat    = ps;
      counter     = cnt;
      clause_size = cs;
      if (!rn) begin
         model_sat = 1'b0;
         eu = 1'b0;
         ec = 1'b0;
      end else begin
         s_eff     = en ? ps : model_sat;
         model_sat = s_eff;
         open_lits = int'(cs) - int'(cnt);
         eu = !s_eff && (cs > 0) && (open_lits == 1);
         ec = !s_eff && (cs > 0) && (open_lits == 0);
      end
      exp_q.push_back({ec, eu});
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] e;
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd3);
      step(1'b0, 1'b1, 1'b0, 8'd2, 8'd3);
      void'(exp_q.pop_front());
      e = exp_q.pop_front();
      n_cmp++;
      if (unit_clause !== e[0]) begin
         n_err++;
         $display("FAIL reset_unit: got %b expected %b", unit_clause, e[0]);
      end
`ifdef UNIT_CHECKER_CONFLICT_EN
      n_cmp++;
      if (conflict !== e[1]) begin
         n_err++;
         $display("FAIL reset_conflict: got %b expected %b", conflict, e[1]);
      end
`endif
   endtask

   // Directed rows: {en, ps, counter, clause_size}, one edge each, checked in order.
   task automatic test_directed();
      logic [1:0]  e;
      logic [17:0] rows[10];
      rows[0] = {1'b1, 1'b1, 8'd3,   8'd3};   // satisfied, all false
      rows[1] = {1'b1, 1'b1, 8'd2,   8'd3};   // satisfied, one open
      rows[2] = {1'b1, 1'b0, 8'd3,   8'd3};   // conflict
      rows[3] = {1'b1, 1'b0, 8'd2,   8'd3};   // unit
      rows[4] = {1'b0, 1'b1, 8'd2,   8'd3};   // held sat_q=0 keeps unit
      rows[5] = {1'b1, 1'b0, 8'd128, 8'd128}; // wide conflict
      rows[6] = {1'b1, 1'b0, 8'd127, 8'd128}; // wide unit
      rows[7] = {1'b1, 1'b0, 8'd255, 8'd0};   // no wrap-around match
      rows[8] = {1'b1, 1'b0, 8'd9,   8'd5};   // illegal count
      rows[9] = {1'b1, 1'b0, 8'd1,   8'd5};   // several open
      for (int i = 0; i < 10; i++) begin
         step(1'b1, rows[i][17], rows[i][16], rows[i][15:8], rows[i][7:0]);
         e = exp_q.pop_front();
         n_cmp++;
         if (unit_clause !== e[0]) begin
            n_err++;
            $display("FAIL directed_unit[%0d]: got %b expected %b", i, unit_clause, e[0]);
         end
`ifdef UNIT_CHECKER_CONFLICT_EN
         n_cmp++;
         if (conflict !== e[1]) begin
            n_err++;
            $display("FAIL directed_conflict[%0d]: got %b expected %b", i, conflict, e[1]);
         end
`endif
      end
   endtask

   // The output must not move between edges when inputs change.
   task automatic test_latency();
      logic [1:0] e;
      step(1'b1, 1'b1, 1'b0, 8'd6, 8'd7);
      e = exp_q.pop_front();
      counter = 8'd0;
      part_sat = 1'b1;
      #2;
      n_cmp++;
      if (unit_clause !== e[0]) begin
         n_err++;
         $display("FAIL latency_hold: got %b expected %b", unit_clause, e[0]);
      end
      step(1'b1, 1'b1, 1'b1, 8'd0, 8'd7);
      e = exp_q.pop_front();
      n_cmp++;
      if (unit_clause !== e[0]) begin
         n_err++;
         $display("FAIL latency_update: got %b expected %b", unit_clause, e[0]);
      end
   endtask

   // Reset while unit is high, and reset clearing a held satisfied flag.
   task automatic test_reset_mid();
      logic [1:0] e;
      logic       got[4];
      logic       want[4];
      step(1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
      e = exp_q.pop_front(); got[0] = unit_clause; want[0] = e[0];
      step(1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
      e = exp_q.pop_front(); got[1] = unit_clause; want[1] = e[0];
      step(1'b1, 1'b0, 1'b1, 8'd1, 8'd2);
      e = exp_q.pop_front(); got[2] = unit_clause; want[2] = e[0];
      step(1'b1, 1'b1, 1'b1, 8'd1, 8'd2);
      step(1'b0, 1'b0, 1'b1, 8'd1, 8'd2);
      step(1'b1, 1'b0, 1'b1, 8'd1, 8'd2);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      e = exp_q.pop_front(); got[3] = unit_clause; want[3] = e[0];
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin
            n_err++;
            $display("FAIL reset_mid[%0d]: got %b expected %b", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] e;
      logic [7:0] cs;
      logic [7:0] cnt;
      logic       rn;
      for (int i = 0; i < 400; i++) begin
         cs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
         case ($urandom_range(0, 3))
            0:       cnt = cs - 8'd1;
            1:       cnt = cs;
            2:       cnt = 8'($urandom_range(0, 255));
            default: cnt = cs - 8'($urandom_range(2, 3));
         endcase
         rn = ($urandom_range(0, 39) != 0);
         step(rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), cnt, cs);
         e = exp_q.pop_front();
         n_cmp++;
         if (unit_clause !== e[0]) begin
            n_err++;
            $display("FAIL random_unit[%0d]: cnt=%0d cs=%0d got %b expected %b",
                     i, cnt, cs, unit_clause, e[0]);
         end
`ifdef UNIT_CHECKER_CONFLICT_EN
         n_cmp++;
         if (conflict !== e[1]) begin
            n_err++;
            $display("FAIL random_conflict[%0d]: got %b expected %b", i, conflict, e[1]);
         end
         n_cmp++;
         if ((conflict & unit_clause) !== 1'b0) begin
            n_err++;
            $display("FAIL random_exclusive[%0d]: got both high, expected at most one", i);
         end
`endif
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      model_sat   = 1'b0;
      reset_n     = 1'b0;
      en_part_sat = 1'b0;
      part_sat    = 1'b0;
      counter     = '0;
      clause_size = '0;
      test_reset();
      test_directed();
      test_latency();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
